// File: rtl/vend_arbiter.sv
// Two-port round-robin vending session controller: collects coins from the granted
// port, vends one item, pays change one unit per cycle and supports cancel/timeout refunds.
module vend_arbiter #(
   parameter int unsigned PRICE      = 5,
   parameter int unsigned STOCK_INIT = 8,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] req,
   input  logic [2:0] money0,
   input  logic [2:0] money1,
   input  logic [1:0] cancel,
   input  logic       restock,
   output logic [1:0] gnt,
   output logic [3:0] val,
   output logic       dispense,
   output logic       change_pulse,
   output logic [3:0] change_left,
   output logic       refund,
   output logic [3:0] stock,
   output logic       sold_out
);
   localparam int unsigned CW = 4;
   localparam int unsigned MW = 3;
   localparam logic [CW-1:0] PRICE_V = CW'(PRICE);
   localparam logic [CW-1:0] STOCK_V = CW'(STOCK_INIT);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

   state_t          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [CW-1:0]   val_q, val_d;
   logic            disp_q, disp_d;
   logic            cpulse_q, cpulse_d;
   logic [CW-1:0]   cl_q, cl_d;
   logic            refund_q, refund_d;
   logic [CW-1:0]   stock_q, stock_d;
   logic            sold_q, sold_d;
   logic            ptr_q, ptr_d;
   logic [CW-1:0]   to_q, to_d;

   logic [MW-1:0]   money_g;
   logic            cancel_g;
   logic [CW-1:0]   coin_sum;
   logic            timeout_hit;

   // Only the granted port is visible to the datapath.
   assign money_g     = gnt_q[1] ? money1 : money0;
   assign cancel_g    = gnt_q[1] ? cancel[1] : cancel[0];
   assign coin_sum    = val_q + CW'(money_g);
   assign timeout_hit = (money_g == '0) && (to_q == TO_LAST);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         val_q    <= '0;
         disp_q   <= 1'b0;
         cpulse_q <= 1'b0;
         cl_q     <= '0;
         refund_q <= 1'b0;
         stock_q  <= STOCK_V;
         sold_q   <= (STOCK_V == '0);
         ptr_q    <= 1'b0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         val_q    <= val_d;
         disp_q   <= disp_d;
         cpulse_q <= cpulse_d;
         cl_q     <= cl_d;
         refund_q <= refund_d;
         stock_q  <= stock_d;
         sold_q   <= sold_d;
         ptr_q    <= ptr_d;
         to_q     <= to_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      val_d    = val_q;
      disp_d   = 1'b0;
      cpulse_d = 1'b0;
      cl_d     = cl_q;
      refund_d = refund_q;
      stock_d  = stock_q;
      ptr_d    = ptr_q;
      to_d     = to_q;

      case (state_q)
         IDLE: begin
            gnt_d    = '0;
            val_d    = '0;
            refund_d = 1'b0;
            to_d     = '0;
            if (restock) stock_d = STOCK_V;
            if ((stock_q != '0) && (req != 2'b00)) begin
               state_d = COLLECT;
               if (req == 2'b11) gnt_d = ptr_q ? 2'b10 : 2'b01;
               else              gnt_d = req;
            end
         end
         COLLECT: begin
            if (val_q >= PRICE_V) begin
               state_d = VEND;
               disp_d  = 1'b1;
            end else if (cancel_g || timeout_hit) begin
               // Same-cycle coin is accepted and paid back with the rest.
               cl_d  = coin_sum;
               val_d = '0;
               ptr_d = ~gnt_q[1];
               if (coin_sum != '0) begin
                  state_d  = CHANGE;
                  refund_d = 1'b1;
                  cpulse_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else begin
               val_d = coin_sum;
               to_d  = (money_g != '0) ? '0 : to_q + 4'd1;
            end
         end
         VEND: begin
            stock_d = stock_q - 4'd1;
            cl_d    = val_q - PRICE_V;
            val_d   = '0;
            ptr_d   = ~gnt_q[1];
            if (val_q != PRICE_V) begin
               state_d  = CHANGE;
               cpulse_d = 1'b1;
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         CHANGE: begin
            cl_d = cl_q - 4'd1;
            if (cl_q <= 4'd1) begin
               state_d  = IDLE;
               gnt_d    = '0;
               refund_d = 1'b0;
               cl_d     = '0;
            end else begin
               cpulse_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      sold_d = (stock_d == '0);
   end

   assign gnt          = gnt_q;
   assign val          = val_q;
   assign dispense     = disp_q;
   assign change_pulse = cpulse_q;
   assign change_left  = cl_q;
   assign refund       = refund_q;
   assign stock        = stock_q;
   assign sold_out     = sold_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Scoreboard bench for vend_arbiter: a session-level model predicts each session's outcome,
// a monitor reconstructs sessions from DUT outputs and compares.
module tb_vend_arbiter;
   localparam int unsigned PRICE      = 5;
   localparam int unsigned STOCK_INIT = 8;
   localparam int unsigned TIMEOUT    = 15;

   logic       clk = 1'b0;
   logic       clr;
   logic [1:0] req;
   logic [2:0] money0, money1;
   logic [1:0] cancel;
   logic       restock;
   logic [1:0] gnt;
   logic [3:0] val;
   logic       dispense, change_pulse;
   logic [3:0] change_left;
   logic       refund;
   logic [3:0] stock;
   logic       sold_out;

   vend_arbiter #(.PRICE(PRICE), .STOCK_INIT(STOCK_INIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .clr(clr), .req(req), .money0(money0), .money1(money1),
      .cancel(cancel), .restock(restock), .gnt(gnt), .val(val), .dispense(dispense),
      .change_pulse(change_pulse), .change_left(change_left), .refund(refund),
      .stock(stock), .sold_out(sold_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int port;
      int disp;
      int pulses;
      int ref_cycles;
      int credit;
      int stock;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   prefer = 0;
   int   m_stock = STOCK_INIT;
   int   plan[$];
   int   plan_cancel = -1;

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic drive_step(input int port, input int coin, input bit canc);
      logic [2:0] junk;
      logic       jc;
      junk = 3'($urandom_range(0, 7));
      jc   = 1'($urandom_range(0, 1));
      if (port == 0) begin
         money0 = 3'(coin); money1 = junk; cancel = {jc, canc};
      end else begin
         money1 = 3'(coin); money0 = junk; cancel = {canc, jc};
      end
   endtask

   // One customer session: outcome decided from coin/cancel/idle rules on plain integers.
   task automatic run_session(input logic [1:0] rq);
      int   port, credit, idle, step, coin;
      bit   canc, done;
      exp_t e;
      port = (rq == 2'b11) ? prefer : (rq[1] ? 1 : 0);
      req  = rq;
      @(negedge clk);
      req = 2'b00;
      check("grant", int'(gnt), 1 << port);
      if (gnt == 2'b00) begin
         plan.delete();
         plan_cancel = -1;
         return;
      end
      credit = 0; idle = 0; step = 0; done = 0;
      while (!done) begin
         if (credit >= int'(PRICE)) begin
            e = '{port, 1, credit - int'(PRICE), 0, credit, m_stock - 1};
            m_stock--;
            exp_q.push_back(e);
            done = 1;
            coin = $urandom_range(0, 7);
            canc = 1'($urandom_range(0, 1));
         end else begin
            if (plan.size() > 0) begin
               coin = plan.pop_front();
               canc = (step == plan_cancel);
            end else begin
               coin = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
               canc = ($urandom_range(0, 19) == 0);
            end
            idle = (coin == 0) ? idle + 1 : 0;
            if (canc || idle >= int'(TIMEOUT)) begin
               e = '{port, 0, credit + coin, credit + coin, credit, m_stock};
               exp_q.push_back(e);
               done = 1;
            end else begin
               credit += coin;
            end
         end
         drive_step(port, coin, canc);
         step++;
         @(negedge clk);
      end
      prefer = 1 - port;
      for (int i = 0; i < 40 && gnt != 2'b00; i++) begin
         money0 = 3'($urandom_range(0, 7));
         money1 = 3'($urandom_range(0, 7));
         cancel = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      check("session_end_gnt", int'(gnt), 0);
      money0 = '0; money1 = '0; cancel = '0;
      plan.delete();
      plan_cancel = -1;
   endtask

   task automatic sold_out_check();
      req = 2'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("soldout_no_grant", int'(gnt), 0);
      end
      check("sold_out_flag", int'(sold_out), 1);
      req     = 2'b00;
      restock = 1'b1;
      @(negedge clk);
      restock = 1'b0;
      check("restock_stock", int'(stock), STOCK_INIT);
      check("restock_sold_out", int'(sold_out), 0);
      m_stock = STOCK_INIT;
   endtask

   // Monitor: rebuilds each session from outputs and scores it when gnt drops.
   initial begin : monitor
      bit   active;
      int   port, disp, pulses, rcyc, peak, first_cl, prev_cl;
      bit   cl_ok;
      exp_t e;
      active = 0;
      port = 0; disp = 0; pulses = 0; rcyc = 0; peak = 0; first_cl = -1; prev_cl = -1; cl_ok = 1;
      forever begin
         @(negedge clk);
         if (clr) begin
            active = 0;
            continue;
         end
         if (!active && gnt != 2'b00) begin
            active = 1;
            port = gnt[1] ? 1 : 0;
            disp = 0; pulses = 0; rcyc = 0; peak = 0;
            first_cl = -1; prev_cl = -1; cl_ok = 1;
            check("gnt_onehot", int'(gnt == 2'b01 || gnt == 2'b10), 1);
         end
         if (active) begin
            if (gnt == 2'b00) begin
               active = 0;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL scoreboard: session ended with no expected entry at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("sess_port", port, e.port);
                  check("sess_dispense", disp, e.disp);
                  check("sess_change_pulses", pulses, e.pulses);
                  check("sess_refund_cycles", rcyc, e.ref_cycles);
                  check("sess_credit", peak, e.credit);
                  check("sess_stock", int'(stock), e.stock);
                  check("sess_sold_out", int'(sold_out), int'(e.stock == 0));
                  check("sess_first_change_left", (pulses > 0) ? first_cl : 0, e.pulses);
                  check("sess_change_countdown", int'(cl_ok), 1);
                  check("sess_change_left_end", int'(change_left), 0);
               end
            end else begin
               if (int'(val) > peak) peak = int'(val);
               if (dispense) disp++;
               if (refund) rcyc++;
               if (change_pulse) begin
                  pulses++;
                  if (prev_cl >= 0 && int'(change_left) != prev_cl - 1) cl_ok = 0;
                  if (first_cl < 0) first_cl = int'(change_left);
                  prev_cl = int'(change_left);
               end
            end
         end else begin
            check("idle_quiet", int'({dispense, change_pulse, refund}), 0);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      clr = 1'b1; req = '0; money0 = '0; money1 = '0; cancel = '0; restock = 1'b0;
      #12;
      check("rst_gnt", int'(gnt), 0);
      check("rst_val", int'(val), 0);
      check("rst_dispense", int'(dispense), 0);
      check("rst_change_pulse", int'(change_pulse), 0);
      check("rst_change_left", int'(change_left), 0);
      check("rst_refund", int'(refund), 0);
      check("rst_stock", int'(stock), STOCK_INIT);
      check("rst_sold_out", int'(sold_out), int'(STOCK_INIT == 0));
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);

      plan = '{2, 3};       run_session(2'b01);
      plan = '{4, 4};       run_session(2'b10);
      for (int i = 0; i < 3; i++) begin
         plan = '{5};
         run_session(2'b11);
      end
      plan = '{3, 1}; plan_cancel = 1; run_session(2'b01);
      plan = '{3};
      for (int i = 0; i < 15; i++) plan.push_back(0);
      run_session(2'b01);

      for (int n = 0; n < 30; n++) begin
         if (m_stock == 0) sold_out_check();
         run_session(2'($urandom_range(1, 3)));
      end
      if (m_stock == 0) sold_out_check();

      // Reset in the middle of a 3-unit change payout.
      req = 2'b01;
      @(negedge clk);
      req = 2'b00;
      check("mid_rst_grant", int'(gnt), 1);
      drive_step(0, 4, 1'b0);
      @(negedge clk);
      drive_step(0, 4, 1'b0);
      @(negedge clk);
      money0 = '0; money1 = '0; cancel = '0;
      for (int i = 0; i < 6 && !change_pulse; i++) @(negedge clk);
      check("mid_rst_in_change", int'(change_pulse), 1);
      #2 clr = 1'b1;
      #1;
      check("mid_rst_gnt", int'(gnt), 0);
      check("mid_rst_val", int'(val), 0);
      check("mid_rst_change_pulse", int'(change_pulse), 0);
      check("mid_rst_change_left", int'(change_left), 0);
      check("mid_rst_refund", int'(refund), 0);
      check("mid_rst_dispense", int'(dispense), 0);
      check("mid_rst_stock", int'(stock), STOCK_INIT);
      @(negedge clk);
      clr = 1'b0;
      m_stock = STOCK_INIT;
      prefer  = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post_rst_no_pulse", int'(change_pulse), 0);
      end
      run_session(2'b11);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vend_arbiter.md
# vend_arbiter

Two-customer vending session controller that sequences one shared accumulate-and-vend datapath. It arbitrates round-robin between two coin ports and accumulates coins from the granted port until the price is met. It then dispenses one item, pays change one unit per cycle, and tracks stock. Cancel and idle-timeout refunds are supported. It sits between the coin-acceptor front ends and the dispense/change actuators.

## Interface
- PRICE, 5, item price in coin units; legal range 1..8.
- STOCK_INIT, 8, stock loaded at reset and on restock; legal range 0..15.
- TIMEOUT, 15, consecutive coinless COLLECT cycles before forced refund; legal range 1..15.
- clk  in  1  clock, all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req  in  2  per-port session request, level.
- money0  in  3  port 0 coin value this cycle; 0 means no coin.
- money1  in  3  port 1 coin value this cycle; 0 means no coin.
- cancel  in  2  per-port cancel, sampled only for the granted port.
- restock  in  1  reload stock to STOCK_INIT, honored only in IDLE.
- gnt  out  2  one-hot grant, or 0 when no session.
- val  out  4  accumulated credit of the current session.
- dispense  out  1  one-cycle item-release pulse.
- change_pulse  out  1  one coin unit returned this cycle.
- change_left  out  4  change units still owed.
- refund  out  1  high through a cancel/timeout payback, i.e. while in CHANGE after a refund.
- stock  out  4  items remaining.
- sold_out  out  1  stock == 0.

## Operation
- FSM states: IDLE, COLLECT, VEND, CHANGE. All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- **IDLE:** gnt = 0 and val = 0.
  - If stock != 0 and any req is high, grant one port and go to COLLECT.
  - Round-robin: the port not served last wins a tie. The pointer starts at port 0 after reset.
  - If stock == 0, req is ignored.
  - restock sets stock = STOCK_INIT.
- **COLLECT:** only the granted port's money and cancel are seen; the other port is ignored entirely.
  - Each cycle: val <= val + money_g (4-bit; cannot overflow because val < PRICE ≤ 8 and money ≤ 7).
  - When val ≥ PRICE at the start of a cycle, go to VEND, and any coin that cycle is ignored.
  - Timeout counter (4 bits) clears on any nonzero coin and increments on coinless cycles. Reaching TIMEOUT acts as a cancel.
- **Cancel or timeout in COLLECT:** change_left <= val + money_g (a coin in the same cycle is accepted, then refunded), refund <= 1 and val <= 0.
  - Go to CHANGE if that sum is nonzero, otherwise go straight to IDLE.
- **VEND (exactly 1 cycle):**
  - dispense = 1, stock <= stock - 1, change_left <= val - PRICE, val <= 0.
  - The pointer moves to the other port.
  - Next state is CHANGE if val - PRICE != 0, else IDLE.
- **CHANGE:** change_pulse = 1 every cycle and change_left decrements each cycle. When change_left goes 1 → 0, the next state is IDLE and gnt and refund clear. Coins and cancel are ignored.
- **Refund pointer:** after a refund session the pointer also moves to the other port.
- **sold_out:** = (stock == 0), updated the cycle after a VEND or restock.
- **Reset mid-session:** any state returns to IDLE immediately. val, change_left, gnt, dispense, change_pulse and refund go to 0; stock = STOCK_INIT; pointer = port 0. Owed change is lost by definition.

## Timing
- Reset values:
  - gnt = 0, val = 0, dispense = 0, change_pulse = 0, change_left = 0, refund = 0.
  - stock = STOCK_INIT, sold_out = (STOCK_INIT == 0).
- Grant latency: req high at edge n in IDLE gives gnt high from edge n+1. A coin is counted only if gnt was already high at the sampling edge.
- Coin-to-val latency: 1 cycle.
- val ≥ PRICE to dispense: 1 cycle (val reaches PRICE at edge k, dispense is high k+1 .. k+2).
- Change of c units: c consecutive change_pulse cycles immediately after VEND. Session length from the completing coin = 2 + c cycles.
- Earliest next grant: the edge after the last CHANGE cycle (or after VEND when c = 0). There are no dead cycles beyond that.

## Test plan
- Exact price: port 0 inserts 2, 3 → val 2, 5; dispense one cycle; change_left 0; stock 8 → 7; gnt 01 → 00.
- Overpay: port 1 inserts 4, 4 → val 8; dispense; change_pulse for 3 consecutive cycles with change_left 3, 2, 1 → 0; stock decrements once.
- Arbitration: req = 11 held continuously with 5-coin sessions → grants alternate 01, 10, 01. Coins on the non-granted port never change val.
- Cancel/timeout:
  - Port 0 inserts 3, then cancel with coin 1 in the same cycle → refund = 1, 4 change pulses, no dispense, stock unchanged.
  - Separately, 3 then 15 coinless cycles → 3-pulse refund.
- Sold out and restock: with STOCK_INIT = 1, one sale → sold_out = 1 and req is ignored. restock in IDLE → stock 1, sold_out 0, and the next req is granted.
- Reset mid-CHANGE: assert clr during a 3-unit change → all outputs are 0 and stock = STOCK_INIT asynchronously. No change_pulse after clr deasserts until a new session.
